// File: rtl/zf_qpsk_slicer_if.sv
// Frame input and decision-beat output of the QPSK slicer.
// The master side is the producer/consumer; the slave side is the slicer.
interface zf_qpsk_slicer_if;
  logic         in_valid;
  logic [255:0] in_data;
  logic         out_ready;
  logic         out_valid;
  logic [3:0]   out_bits;
  logic         out_col;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_bits, out_col, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_bits, out_col, out_last
  );
endinterface

// File: rtl/zf_qpsk_slicer.sv
// Hard QPSK slicer for the zero-forcing detector output.
// Buffers sliced frames and emits one 4-bit decision pair per column.
module zf_qpsk_slicer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  zf_qpsk_slicer_if.slave  bus,
  output logic             overflow,
  output logic [CNT_W-1:0] nan_cnt,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, COL0, COL1} state_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  function automatic logic neg_bit(input logic [31:0] w);
    return w[31] && (w[30:0] != 31'd0) && !is_nan(w);
  endfunction

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [7:0]       dec;
  logic [7:0]       entry;
  logic [3:0]       frame_nans;
  logic [CNT_W:0]   nan_sum;
  logic [7:0]       head, after_head;
  logic             wr, pop;
  logic             valid_nxt, col_nxt, last_nxt;
  logic [3:0]       bits_nxt;

  always_comb begin
    dec        = '0;
    frame_nans = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      dec[k]     = neg_bit(bus.in_data[255 - 32*k -: 32]);
      frame_nans = frame_nans + 4'(is_nan(bus.in_data[255 - 32*k -: 32]));
    end
  end

  // Entry holds both column nibbles already in beat order {row0,row2,row1,row3}.
  assign entry = {dec[0], dec[4], dec[2], dec[6], dec[1], dec[5], dec[3], dec[7]};

  assign nan_sum = {1'b0, nan_cnt} + (CNT_W + 1)'(frame_nans);

  assign pop = (state == COL1) && bus.out_ready;
  assign wr  = bus.in_valid && ((count != FULL) || pop);

  always_comb begin
    count_nxt = count;
    case ({wr, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  assign head = mem[rd_ptr];
  // With one entry left, the frame following the popped one is the one being written now.
  assign after_head = (count == CNT_ONE) ? entry : mem[rd_ptr + PTR_ONE];

  always_comb begin
    state_nxt = state;
    valid_nxt = bus.out_valid;
    bits_nxt  = bus.out_bits;
    col_nxt   = bus.out_col;
    last_nxt  = bus.out_last;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = COL0;
          valid_nxt = 1'b1;
          bits_nxt  = head[7:4];
          col_nxt   = 1'b0;
          last_nxt  = 1'b0;
        end
      end
      COL0: begin
        if (bus.out_ready) begin
          state_nxt = COL1;
          bits_nxt  = head[3:0];
          col_nxt   = 1'b1;
          last_nxt  = 1'b1;
        end
      end
      COL1: begin
        if (bus.out_ready) begin
          col_nxt  = 1'b0;
          last_nxt = 1'b0;
          if (count_nxt != '0) begin
            state_nxt = COL0;
            bits_nxt  = after_head[7:4];
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            bits_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        bits_nxt  = '0;
        col_nxt   = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_bits  <= '0;
      bus.out_col   <= 1'b0;
      bus.out_last  <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      nan_cnt       <= '0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      bus.out_valid <= valid_nxt;
      bus.out_bits  <= bits_nxt;
      bus.out_col   <= col_nxt;
      bus.out_last  <= last_nxt;
      count         <= count_nxt;
      if (wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (bus.in_valid) begin
        nan_cnt <= nan_sum[CNT_W] ? '1 : nan_sum[CNT_W-1:0];
        if (!wr) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zf_qpsk_slicer.sv
// Bench for zf_qpsk_slicer: directed cases with literal expectations plus
// randomized traffic checked every cycle against a frame-queue model.
module tb_zf_qpsk_slicer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  localparam logic [31:0] P = 32'h3F800000;
  localparam logic [31:0] M = 32'hBF800000;
  localparam logic [255:0] F1 = {P, M, M, M, M, M, P, M};
  localparam logic [255:0] FS = {32'h80000000, P, 32'h7FC00000, P,
                                 32'hFF800000, P, 32'h00000001, P};

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             overflow;
  logic [CNT_W-1:0] nan_cnt;
  logic [CNT_W-1:0] frame_cnt;

  zf_qpsk_slicer_if ifc ();

  zf_qpsk_slicer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc.slave),
    .overflow  (overflow),
    .nan_cnt   (nan_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int beats    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] word_of(input logic [255:0] d, input int k);
    return d[255 - 32*k -: 32];
  endfunction

  function automatic bit w_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction

  function automatic bit w_bit(input logic [31:0] w);
    return w[31] && (w[30:0] != 0) && !w_nan(w);
  endfunction

  function automatic logic [3:0] exp_beat(input logic [255:0] d, input int c);
    return {w_bit(word_of(d, c)), w_bit(word_of(d, 4 + c)),
            w_bit(word_of(d, 2 + c)), w_bit(word_of(d, 6 + c))};
  endfunction

  function automatic int nans_of(input logic [255:0] d);
    int n = 0;
    for (int k = 0; k < 8; k++) if (w_nan(word_of(d, k))) n++;
    return n;
  endfunction

  logic [255:0] mq[$];
  int pos    = 0;     // 0: nothing shown, 1: column 0 of mq[0] shown, 2: column 1 shown
  bit m_ovf  = 0;
  int m_nan  = 0;
  int m_fcnt = 0;
  bit hs, pop_m, acc;
  int sz0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      pos = 0; m_ovf = 0; m_nan = 0; m_fcnt = 0;
    end else begin
      hs    = (pos != 0) && ifc.out_ready;
      pop_m = hs && (pos == 2);
      sz0   = mq.size();
      acc   = ifc.in_valid && ((sz0 < DEPTH) || pop_m);
      if (ifc.in_valid) begin
        m_nan = m_nan + nans_of(ifc.in_data);
        if (m_nan > (1 << CNT_W) - 1) m_nan = (1 << CNT_W) - 1;
        if (!acc) m_ovf = 1;
      end
      if (pop_m) begin
        void'(mq.pop_front());
        m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
      end
      if (acc) mq.push_back(ifc.in_data);
      if (pos == 0)              pos = (sz0 > 0) ? 1 : 0;
      else if (hs && pos == 1)   pos = 2;
      else if (pop_m)            pos = (mq.size() > 0) ? 1 : 0;
    end
  end

  always @(posedge clk)
    if (!reset && ifc.out_valid && ifc.out_ready) beats++;

  always @(negedge clk) begin
    if (!reset) begin
      check("m_out_valid", ifc.out_valid, (pos != 0));
      if (pos != 0) begin
        check("m_out_bits", ifc.out_bits, exp_beat(mq[0], pos - 1));
        check("m_out_col",  ifc.out_col,  (pos == 2));
        check("m_out_last", ifc.out_last, (pos == 2));
      end
      check("m_overflow",  overflow,  m_ovf);
      check("m_nan_cnt",   nan_cnt,   m_nan);
      check("m_frame_cnt", frame_cnt, m_fcnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] d);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    step(1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    int i = 0;
    while (!ifc.out_valid && i < n) begin
      @(negedge clk);
      i++;
    end
    check("wait_valid", ifc.out_valid, 1);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 9))
      0: return 32'h80000000;
      1: return 32'h00000000;
      2: return {9'h0FF, 1'b1, 22'($urandom)};
      3: return 32'h7F800000;
      4: return 32'hFF800000;
      5: return {9'h1FF, 23'($urandom_range(1, 8388607))};
      default: return $urandom;
    endcase
  endfunction

  task automatic beat_pair(input string tag, input logic [3:0] b0, input logic [3:0] b1);
    @(negedge clk);
    check({tag, "_lat_idle"}, ifc.out_valid, 0);
    @(negedge clk);
    check({tag, "_c0_valid"}, ifc.out_valid, 1);
    check({tag, "_c0_bits"},  ifc.out_bits, b0);
    check({tag, "_c0_col"},   ifc.out_col, 0);
    check({tag, "_c0_last"},  ifc.out_last, 0);
    @(negedge clk);
    check({tag, "_c1_bits"},  ifc.out_bits, b1);
    check({tag, "_c1_col"},   ifc.out_col, 1);
    check({tag, "_c1_last"},  ifc.out_last, 1);
    @(negedge clk);
    check({tag, "_done_valid"}, ifc.out_valid, 0);
  endtask

  logic [255:0] rf;

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    @(negedge clk);
    check("rst_valid", ifc.out_valid, 0);
    check("rst_bits",  ifc.out_bits, 0);
    check("rst_col",   ifc.out_col, 0);
    check("rst_last",  ifc.out_last, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_nan",   nan_cnt, 0);
    check("rst_fcnt",  frame_cnt, 0);

    // single frame, latency and decisions
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    send(F1);
    beat_pair("single", 4'b0110, 4'b1111);
    check("single_fcnt", frame_cnt, 1);

    // special values
    step(1);
    send(FS);
    beat_pair("special", 4'b0100, 4'b0000);
    check("special_nan", nan_cnt, 1);

    // backpressure on column 0
    step(1);
    ifc.out_ready = 1'b0;
    send(F1);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", ifc.out_valid, 1);
      check("bp_bits",  ifc.out_bits, 4'b0110);
      check("bp_col",   ifc.out_col, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("bp_hold_col", ifc.out_col, 0);
    @(negedge clk);
    check("bp_c1_col",  ifc.out_col, 1);
    check("bp_c1_bits", ifc.out_bits, 4'b1111);
    step(3);
    check("bp_fcnt", frame_cnt, 3);

    // full buffer with a write coinciding with the column-1 pop
    ifc.out_ready = 1'b0;
    beats = 0;
    send(F1);
    step(3);
    send(FS);
    step(2);
    ifc.out_ready = 1'b1;
    step(1);
    send(F1);
    step(10);
    check("cpop_beats", beats, 6);
    check("cpop_ovf",   overflow, 0);
    check("cpop_fcnt",  frame_cnt, 6);
    check("cpop_nan",   nan_cnt, 2);

    // overflow: third frame dropped
    ifc.out_ready = 1'b0;
    beats = 0;
    send(F1); step(3);
    send(F1); step(3);
    send(F1); step(3);
    check("ovf_set", overflow, 1);
    ifc.out_ready = 1'b1;
    step(12);
    check("ovf_beats", beats, 4);
    check("ovf_fcnt",  frame_cnt, 8);
    check("ovf_sticky", overflow, 1);

    // reset during a column-0 stall
    ifc.out_ready = 1'b0;
    send(F1);
    wait_valid(10);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", ifc.out_valid, 0);
    check("mid_rst_bits",  ifc.out_bits, 0);
    check("mid_rst_col",   ifc.out_col, 0);
    check("mid_rst_last",  ifc.out_last, 0);
    check("mid_rst_ovf",   overflow, 0);
    check("mid_rst_nan",   nan_cnt, 0);
    check("mid_rst_fcnt",  frame_cnt, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    send(F1);
    beat_pair("post_rst", 4'b0110, 4'b1111);
    check("post_rst_fcnt", frame_cnt, 1);

    // randomized traffic against the model
    for (int f = 0; f < 300; f++) begin
      for (int k = 0; k < 8; k++) rf[255 - 32*k -: 32] = rnd_word();
      ifc.out_ready = ($urandom_range(0, 9) < 7);
      send(rf);
      for (int g = 0; g < int'($urandom_range(3, 7)); g++) begin
        ifc.out_ready = ($urandom_range(0, 9) < 7);
        step(1);
      end
    end
    ifc.out_ready = 1'b1;
    step(20);
    check("rand_drained", ifc.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
